// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of uart_tx_fifo; master = bus/driver side, slave = FIFO.
// tx_empty_irq_o exists only when UART_TX_FIFO_IRQ_EN is defined.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              clr_i;
    logic              wr_en_i;
    logic [7:0]        wr_data_i;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   count_o;
    logic              overflow_o;
    logic              busy_o;
    logic              tx_dv_o;
    logic [7:0]        tx_byte_o;
    logic              tx_done_i;
`ifdef UART_TX_FIFO_IRQ_EN
    logic              tx_empty_irq_o;
`endif

    modport master (
        output clr_i, wr_en_i, wr_data_i, tx_done_i,
        input  full_o, empty_o, count_o, overflow_o, busy_o, tx_dv_o, tx_byte_o
`ifdef UART_TX_FIFO_IRQ_EN
        , input tx_empty_irq_o
`endif
    );

    modport slave (
        input  clr_i, wr_en_i, wr_data_i, tx_done_i,
        output full_o, empty_o, count_o, overflow_o, busy_o, tx_dv_o, tx_byte_o
`ifdef UART_TX_FIFO_IRQ_EN
        , output tx_empty_irq_o
`endif
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO + launch sequencer ahead of UART_TX; UART_TX_FIFO_IRQ_EN adds tx_empty_irq_o.
// Latency: a byte pushed into an empty FIFO with the sequencer idle launches one edge later.
// Backpressure: none; pushes while full are dropped and set the sticky overflow_o.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DONE = 2'b01,
        GAP       = 2'b10
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                tx_dv;
    logic [7:0]          tx_byte;
    logic                launch;
    logic                push;
    logic                empty;
    logic                full;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // full is the pre-edge value, so a pop in the same cycle does not open a slot for the push
    assign push  = bus.wr_en_i && !full && !bus.clr_i;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    launch    = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_i) begin
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            tx_dv <= launch;
            if (launch) begin
                tx_byte <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data_i;
        end
    end

    // clr_i flushes the queue only; the sequencer keeps running so an in-flight byte completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr_en_i && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_IRQ_EN
    logic tx_empty_irq;

    // Leaving GAP with nothing queued means the last byte has fully gone out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_empty_irq <= 1'b0;
        end else begin
            tx_empty_irq <= (state == GAP) && empty && !push;
        end
    end

    assign bus.tx_empty_irq_o = tx_empty_irq;
`endif

    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
    assign bus.busy_o     = (state != IDLE);
    assign bus.tx_dv_o    = tx_dv;
    assign bus.tx_byte_o  = tx_byte;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of pushed bytes, transmitter model, per-scenario tasks.
module tb_uart_tx_fifo;
    logic clk;
    logic rst;

    uart_tx_fifo_if #(.ADDR_W(4)) bus ();

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;
    int         cyc = 0;
    int         launches = 0;
    int         last_done_cyc = -1;
    int         irq_cnt = 0;
    int         irq_cyc = -1;
    int         done_delay = 3;
    int         model_n;
    bit         hold_done = 0;
    bit         b2b_chk = 0;
    bit         prev_dv = 0;
    bit         prev_irq = 0;
    logic       model_done;
    logic       spur_done;

    assign bus.tx_done_i = model_done | spur_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Transmitter model: done pulse done_delay cycles after each launch, aborted by reset
    always begin
        @(negedge clk);
        if (rst && bus.tx_dv_o) begin
            model_n = 0;
            while (rst && (model_n < done_delay || hold_done)) begin
                @(posedge clk);
                model_n++;
            end
            if (rst) begin
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    // Output monitor: every launch pops the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (bus.tx_done_i) last_done_cyc = cyc;
            if (bus.tx_dv_o) begin
                launches++;
                checks++; if (prev_dv) begin fails++; $display("FAIL dv_width: tx_dv_o high on two consecutive cycles"); end else passed++;
                checks++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL launch_unexpected: got byte %h, expected no launch", bus.tx_byte_o);
                end else begin
                    exp_b = sb.pop_front();
                    if (bus.tx_byte_o !== exp_b) begin fails++; $display("FAIL launch_byte: got %h want %h", bus.tx_byte_o, exp_b); end else passed++;
                end
                if (b2b_chk && last_done_cyc >= 0) begin
                    checks++; if (cyc - last_done_cyc !== 3) begin fails++; $display("FAIL b2b_gap: got %0d want 3", cyc - last_done_cyc); end else passed++;
                end
            end
`ifdef UART_TX_FIFO_IRQ_EN
            if (bus.tx_empty_irq_o) begin
                irq_cnt++;
                irq_cyc = cyc;
                checks++; if (prev_irq) begin fails++; $display("FAIL irq_width: tx_empty_irq_o high two cycles"); end else passed++;
            end
            prev_irq = bus.tx_empty_irq_o;
`endif
        end
        prev_dv = bus.tx_dv_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", fails);
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus.busy_o && bus.empty_o && !bus.tx_dv_o && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.clr_i = 0; bus.wr_en_i = 0; bus.wr_data_i = 8'h00;
        model_done = 0; spur_done = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.empty_o !== 1'b1) begin fails++; $display("FAIL por_empty: got %b want 1", bus.empty_o); end else passed++;
        checks++; if (bus.count_o !== 5'd0) begin fails++; $display("FAIL por_count: got %0d want 0", bus.count_o); end else passed++;
        checks++; if ({bus.full_o, bus.overflow_o, bus.busy_o, bus.tx_dv_o} !== 4'b0) begin fails++; $display("FAIL por_flags: got %b want 0000", {bus.full_o, bus.overflow_o, bus.busy_o, bus.tx_dv_o}); end else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        // mid-run: queue three bytes, let one launch, then reset between edges
        hold_done = 1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_i = 1; bus.wr_data_i = 8'h51 + 8'(i); sb.push_back(8'h51 + 8'(i));
            @(posedge clk); #1;
        end
        bus.wr_en_i = 0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks++; if ({bus.tx_dv_o, bus.busy_o, bus.full_o, bus.overflow_o} !== 4'b0) begin fails++; $display("FAIL rst_flags: got %b want 0000", {bus.tx_dv_o, bus.busy_o, bus.full_o, bus.overflow_o}); end else passed++;
        checks++; if (bus.count_o !== 5'd0 || bus.empty_o !== 1'b1) begin fails++; $display("FAIL rst_count: got count %0d empty %b want 0/1", bus.count_o, bus.empty_o); end else passed++;
        checks++; if (bus.tx_byte_o !== 8'h00) begin fails++; $display("FAIL rst_byte: got %h want 00", bus.tx_byte_o); end else passed++;
        sb.delete();
        hold_done = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int  lc;
        bit  ok;
        done_delay = 10;
        spur_done = 1;
        @(posedge clk); #1 spur_done = 0;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL spurious_done: busy got %b want 0", bus.busy_o); end else passed++;
        @(posedge clk); #1;
        bus.wr_en_i = 1; bus.wr_data_i = 8'hA5; sb.push_back(8'hA5);
        @(posedge clk); #1 bus.wr_en_i = 0;
        @(negedge clk);
        checks++; if (bus.tx_dv_o !== 1'b0 || bus.count_o !== 5'd1) begin fails++; $display("FAIL single_e0: got dv %b count %0d want 0/1", bus.tx_dv_o, bus.count_o); end else passed++;
        @(negedge clk);
        lc = cyc;
        checks++; if (bus.tx_dv_o !== 1'b1 || bus.tx_byte_o !== 8'hA5) begin fails++; $display("FAIL single_e1: got dv %b byte %h want 1/a5", bus.tx_dv_o, bus.tx_byte_o); end else passed++;
        checks++; if (bus.count_o !== 5'd0 || bus.busy_o !== 1'b1) begin fails++; $display("FAIL single_pop: got count %0d busy %b want 0/1", bus.count_o, bus.busy_o); end else passed++;
        @(negedge clk);
        checks++; if (bus.tx_dv_o !== 1'b0 || bus.tx_byte_o !== 8'hA5) begin fails++; $display("FAIL single_e2: got dv %b byte %h want 0/a5", bus.tx_dv_o, bus.tx_byte_o); end else passed++;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.tx_done_i) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin fails++; $display("FAIL single_done_wait: got timeout want done pulse"); end else passed++;
        checks++; if (cyc - lc !== 10) begin fails++; $display("FAIL single_done_delay: got %0d want 10", cyc - lc); end else passed++;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL single_gap: busy got %b want 1", bus.busy_o); end else passed++;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL single_idle: busy got %b want 0", bus.busy_o); end else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        int l0;
        bit ok;
        done_delay = 12;
        last_done_cyc = -1;
        b2b_chk = 1;
        l0 = launches;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en_i = 1; bus.wr_data_i = 8'(i); sb.push_back(8'(i));
            @(posedge clk); #1;
        end
        bus.wr_en_i = 0;
        checks++; if (bus.count_o !== 5'd15 || bus.full_o !== 1'b0) begin fails++; $display("FAIL burst_count: got count %0d full %b want 15/0", bus.count_o, bus.full_o); end else passed++;
        wait_drain(600, ok);
        checks++; if (!ok) begin fails++; $display("FAIL burst_drain: got timeout want drained"); end else passed++;
        checks++; if (launches - l0 !== 16) begin fails++; $display("FAIL burst_launches: got %0d want 16", launches - l0); end else passed++;
        b2b_chk = 0;
    endtask

    task automatic test_overflow();
        int l0;
        bit ok;
        done_delay = 3;
        hold_done = 1;
        l0 = launches;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en_i = 1; bus.wr_data_i = 8'h20 + 8'(i); sb.push_back(8'h20 + 8'(i));
            @(posedge clk); #1;
        end
        checks++; if (bus.count_o !== 5'd16 || bus.full_o !== 1'b1 || bus.overflow_o !== 1'b0) begin fails++; $display("FAIL ovf_full: got count %0d full %b ovf %b want 16/1/0", bus.count_o, bus.full_o, bus.overflow_o); end else passed++;
        bus.wr_data_i = 8'h31;
        @(posedge clk); #1 bus.wr_en_i = 0;
        checks++; if (bus.count_o !== 5'd16 || bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_reject: got count %0d ovf %b want 16/1", bus.count_o, bus.overflow_o); end else passed++;
        bus.clr_i = 1; bus.wr_en_i = 1; bus.wr_data_i = 8'h77;
        @(posedge clk); #1 bus.clr_i = 0; bus.wr_en_i = 0;
        sb.delete();
        checks++; if (bus.count_o !== 5'd0 || bus.overflow_o !== 1'b0 || bus.empty_o !== 1'b1) begin fails++; $display("FAIL clr_state: got count %0d ovf %b empty %b want 0/0/1", bus.count_o, bus.overflow_o, bus.empty_o); end else passed++;
        checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL clr_inflight: busy got %b want 1", bus.busy_o); end else passed++;
        hold_done = 0;
        wait_drain(100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL clr_drain: got timeout want drained"); end else passed++;
        checks++; if (launches - l0 !== 1) begin fails++; $display("FAIL clr_launches: got %0d want 1", launches - l0); end else passed++;
    endtask

    task automatic test_wrap();
        logic [4:0] cnt_b;
        bit         ok;
        done_delay = 3;
        for (int i = 0; i < 2; i++) begin
            bus.wr_en_i = 1; bus.wr_data_i = 8'h80 + 8'(i); sb.push_back(8'h80 + 8'(i));
            @(posedge clk); #1;
        end
        bus.wr_en_i = 0;
        for (int i = 0; i < 38; i++) begin
            ok = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.tx_done_i) begin ok = 1; break; end
            end
            checks++; if (!ok) begin fails++; $display("FAIL wrap_done_wait: got timeout want done at byte %0d", i); end else passed++;
            if (!ok) break;
            @(posedge clk); #1;
            @(posedge clk); #1;
            cnt_b = bus.count_o;
            bus.wr_en_i = 1; bus.wr_data_i = 8'h82 + 8'(i); sb.push_back(8'h82 + 8'(i));
            @(posedge clk); #1 bus.wr_en_i = 0;
            checks++; if (bus.count_o !== cnt_b || bus.tx_dv_o !== 1'b1) begin fails++; $display("FAIL wrap_simul: got count %0d dv %b want %0d/1", bus.count_o, bus.tx_dv_o, cnt_b); end else passed++;
        end
        wait_drain(100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL wrap_drain: got timeout want drained"); end else passed++;
    endtask

`ifdef UART_TX_FIFO_IRQ_EN
    task automatic test_irq();
        int i0;
        bit ok;
        done_delay = 3;
        i0 = irq_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_i = 1; bus.wr_data_i = 8'hC0 + 8'(i); sb.push_back(8'hC0 + 8'(i));
            @(posedge clk); #1;
        end
        bus.wr_en_i = 0;
        wait_drain(100, ok);
        repeat (4) @(negedge clk);
        checks++; if (!ok) begin fails++; $display("FAIL irq_drain: got timeout want drained"); end else passed++;
        checks++; if (irq_cnt - i0 !== 1) begin fails++; $display("FAIL irq_count: got %0d want 1", irq_cnt - i0); end else passed++;
        checks++; if (irq_cyc - last_done_cyc !== 2) begin fails++; $display("FAIL irq_timing: got %0d want 2", irq_cyc - last_done_cyc); end else passed++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
`ifdef UART_TX_FIFO_IRQ_EN
        test_irq();
`endif
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
